// File: rtl/axi_model_pkg.sv
// Shared state encodings, default parameters and the byte-lane merge helper.
package axi_model_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 32;
    localparam int unsigned DEF_ADDR_WIDTH    = 32;
    localparam int unsigned DEF_IDX_WIDTH     = 8;
    localparam int unsigned DEF_READ_LATENCY  = 2;
    localparam int unsigned DEF_BRESP_LATENCY = 1;

    typedef enum logic [1:0] { R_IDLE, R_LAT, R_BURST } rd_state_e;
    typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } wr_state_e;

    // Replace the byte lanes of old_word selected by strb with those of new_word
    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_burst_mem_model_if.sv
// AXI-style burst bus between a master and the memory model.
interface axi_burst_mem_model_if
    import axi_model_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic                  proto_err;

    modport slave (
        input  araddr, arlen, arvalid, output arready,
        output rdata, rlast, rvalid,   input  rready,
        input  awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bvalid, input bready, output proto_err
    );

    modport master (
        output araddr, arlen, arvalid, input  arready,
        input  rdata, rlast, rvalid,   output rready,
        output awaddr, awlen, awvalid, input  awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bvalid, output bready, input proto_err
    );
endinterface

// File: rtl/model_word_store.sv
// Word array with per-word valid bits; unwritten words read back as their own address.
module model_word_store
    import axi_model_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [3:0]            wr_strb_i
);
    localparam int unsigned DEPTH = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] wr_old;

    // Index by word address (aliasing above the array size); fill pattern uses the full address
    always_comb begin
        rd_idx    = rd_addr_i[IDX_WIDTH+1:2];
        wr_idx    = wr_addr_i[IDX_WIDTH+1:2];
        rd_data_o = valid_q[rd_idx] ? mem_q[rd_idx] : DATA_WIDTH'(rd_addr_i);
        wr_old    = valid_q[wr_idx] ? mem_q[wr_idx] : DATA_WIDTH'(wr_addr_i);
    end

    // Word contents: merge strobed lanes over the current (or fill) value
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_idx] <= strb_merge(wr_old, wr_data_i, wr_strb_i);
    end

    // Valid bits: cleared by reset, set on any write to the word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_burst_mem_model.sv
// AXI burst memory model: independent read and write burst engines over one word store.
module axi_burst_mem_model
    import axi_model_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned IDX_WIDTH     = DEF_IDX_WIDTH,
    parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
    parameter int unsigned BRESP_LATENCY = DEF_BRESP_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_burst_mem_model_if.slave bus
);

    rd_state_e             r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,  r_addr_d;
    logic [7:0]            r_len_q,   r_len_d;
    logic [8:0]            r_beat_q,  r_beat_d;
    logic [3:0]            r_lat_q,   r_lat_d;
    logic [ADDR_WIDTH-1:0] r_beat_addr;
    logic                  r_last_beat;
    logic [DATA_WIDTH-1:0] r_word;

    wr_state_e             w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q,  w_addr_d;
    logic [7:0]            w_len_q,   w_len_d;
    logic [8:0]            w_beat_q,  w_beat_d;
    logic [3:0]            w_bcnt_q,  w_bcnt_d;
    logic                  perr_q,    perr_d;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic                  w_last_beat;
    logic                  w_en;

    // Beat addresses (wrapping) and last-beat flags from the latched bursts
    always_comb begin
        r_beat_addr = r_addr_q + ADDR_WIDTH'({r_beat_q, 2'b00});
        r_last_beat = (r_beat_q == {1'b0, r_len_q});
        w_beat_addr = w_addr_q + ADDR_WIDTH'({w_beat_q, 2'b00});
        w_last_beat = (w_beat_q == {1'b0, w_len_q});
        w_en        = (w_state_q == W_DATA) && bus.wvalid;
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_lat_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_lat_q   <= r_lat_d;
        end
    end

    // Read FSM next state; R_LAT is skipped entirely when the latency is a single cycle
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_lat_d   = r_lat_q;
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    r_addr_d = bus.araddr;
                    r_len_d  = bus.arlen;
                    r_beat_d = '0;
                    r_lat_d  = 4'(READ_LATENCY - 1);
                    if (READ_LATENCY > 1) r_state_d = R_LAT;
                    else                  r_state_d = R_BURST;
                end
            end
            R_LAT: begin
                r_lat_d = r_lat_q - 4'd1;
                if (r_lat_q <= 4'd1) r_state_d = R_BURST;
            end
            R_BURST: begin
                if (bus.rready) begin
                    if (r_last_beat) r_state_d = R_IDLE;
                    else             r_beat_d  = r_beat_q + 9'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        bus.arready = (r_state_q == R_IDLE);
        bus.rvalid  = (r_state_q == R_BURST);
        bus.rlast   = (r_state_q == R_BURST) && r_last_beat;
        bus.rdata   = (r_state_q == R_BURST) ? r_word : '0;
    end

    // Write FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_bcnt_q  <= '0;
            perr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_bcnt_q  <= w_bcnt_d;
            perr_q    <= perr_d;
        end
    end

    // Write FSM next state; the burst length comes from awlen regardless of wlast
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_bcnt_d  = w_bcnt_q;
        perr_d    = perr_q;
        case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid) begin
                    w_addr_d  = bus.awaddr;
                    w_len_d   = bus.awlen;
                    w_beat_d  = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    if (bus.wlast != w_last_beat) perr_d = 1'b1;
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                        w_bcnt_d  = 4'(BRESP_LATENCY - 1);
                    end else begin
                        w_beat_d  = w_beat_q + 9'd1;
                    end
                end
            end
            W_RESP: begin
                if (w_bcnt_q != '0)  w_bcnt_d  = w_bcnt_q - 4'd1;
                else if (bus.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs
    always_comb begin
        bus.awready   = (w_state_q == W_IDLE);
        bus.wready    = (w_state_q == W_DATA);
        bus.bvalid    = (w_state_q == W_RESP) && (w_bcnt_q == '0);
        bus.proto_err = perr_q;
    end

    model_word_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_addr_i(r_beat_addr),
        .rd_data_o(r_word),
        .wr_en_i  (w_en),
        .wr_addr_i(w_beat_addr),
        .wr_data_i(bus.wdata),
        .wr_strb_i(bus.wstrb)
    );

endmodule

// File: tb/tb_axi_burst_mem_model.sv
// Randomized self-checking bench for axi_burst_mem_model against a word-level reference model.
module tb_axi_burst_mem_model;
    import axi_model_pkg::*;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned B_LAT  = 1;
    localparam int unsigned IDX    = 8;
    localparam int unsigned NWORDS = 1 << IDX;

    logic clk;
    logic rst;

    axi_burst_mem_model_if #(.ADDR_WIDTH(32)) bus ();

    axi_burst_mem_model #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .IDX_WIDTH    (IDX),
        .READ_LATENCY (RD_LAT),
        .BRESP_LATENCY(B_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: written words by index, plus sticky protocol-error flag
    logic [31:0] m_mem [NWORDS];
    bit          m_val [NWORDS];
    bit          m_perr;

    logic [31:0] wd_q [$];
    logic [3:0]  ws_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        int unsigned idx;
        idx = int'((a >> 2) % NWORDS);
        return m_val[idx] ? m_mem[idx] : a;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        int unsigned idx;
        idx = int'((a >> 2) % NWORDS);
        w   = exp_word(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        m_mem[idx] = w;
        m_val[idx] = 1'b1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(NWORDS); i++) m_val[i] = 1'b0;
        m_perr = 1'b0;
    endfunction

    // mode 0: rready always high, 1: toggles starting high, 2: random
    task automatic do_read(input logic [31:0] addr, input int unsigned len, input int unsigned mode);
        int unsigned lat, beat, cyc, nburst;
        logic [31:0] prev, prev_exp, e;
        bit prev_stall;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arvalid = 1'b1;
        check_eq("ar_ready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        lat = 1;
        while (!bus.rvalid && lat < 100) begin @(posedge clk); #1; lat++; end
        check_eq("rd_latency", lat, RD_LAT);
        beat = 0; cyc = 0; nburst = 0; prev_stall = 0; prev = '0; prev_exp = '0;
        while (beat <= len && cyc < 2000) begin
            case (mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = (cyc % 2 == 0);
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            #0;
            if (bus.rvalid) begin
                nburst++;
                e = exp_word(addr + 32'(beat * 4));
                check_eq("rdata", bus.rdata, e);
                check_eq("rlast", bus.rlast, beat == len);
                if (prev_stall && e == prev_exp) check_eq("rd_hold", bus.rdata, prev);
                if (beat == len) check_eq("ar_busy", bus.arready, 0);
                prev = bus.rdata; prev_exp = e; prev_stall = !bus.rready;
                if (bus.rready) beat++;
            end else begin
                check_eq("rd_valid_drop", bus.rvalid, 1);
            end
            @(posedge clk); #1; cyc++;
        end
        bus.rready = 1'b0;
        if (beat <= len) check_eq("rd_timeout", beat, len + 1);
        if (mode == 0) check_eq("rd_cycles", nburst, len + 1);
        if (mode == 1) check_eq("rd_cycles", nburst, 2 * len + 1);
        check_eq("rd_done_valid", bus.rvalid, 0);
        check_eq("rd_done_arready", bus.arready, 1);
    endtask

    // Data/strobes are taken from wd_q/ws_q; wlast is driven only on beat wlast_beat
    task automatic do_write(input logic [31:0] addr, input int unsigned len,
                            input int unsigned wlast_beat, input bit gaps);
        int unsigned lat;
        logic [31:0] d, a;
        logic [3:0]  s;
        bit hs;
        bus.awaddr  = addr;
        bus.awlen   = 8'(len);
        bus.awvalid = 1'b1;
        check_eq("aw_ready", bus.awready, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int unsigned beat = 0; beat <= len; beat++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.wvalid = 1'b0;
                check_eq("w_ready_gap", bus.wready, 1);
                @(posedge clk); #1;
            end
            d = wd_q.pop_front();
            s = ws_q.pop_front();
            a = addr + 32'(beat * 4);
            bus.wvalid = 1'b1;
            bus.wdata  = d;
            bus.wstrb  = s;
            bus.wlast  = (beat == wlast_beat);
            check_eq("w_ready", bus.wready, 1);
            check_eq("b_early", bus.bvalid, 0);
            hs = bus.wready;
            @(posedge clk);
            if (hs) begin
                model_write(a, d, s);
                if ((beat == wlast_beat) != (beat == len)) m_perr = 1'b1;
            end
            #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        lat = 1;
        while (!bus.bvalid && lat < 100) begin @(posedge clk); #1; lat++; end
        check_eq("b_latency", lat, B_LAT);
        check_eq("proto_err", bus.proto_err, m_perr);
        repeat ($urandom_range(0, 2)) begin
            check_eq("b_hold", bus.bvalid, 1);
            @(posedge clk); #1;
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check_eq("b_once", bus.bvalid, 0);
        check_eq("aw_ready_after", bus.awready, 1);
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [3:0] s);
        wd_q.push_back(d);
        ws_q.push_back(s);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        int unsigned len, op, hs, cyc;
        bit saw_b;

        rst = 1'b1;
        bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_arready", bus.arready, 1);
        check_eq("rst_awready", bus.awready, 1);
        check_eq("rst_rvalid", bus.rvalid, 0);
        check_eq("rst_rlast", bus.rlast, 0);
        check_eq("rst_wready", bus.wready, 0);
        check_eq("rst_bvalid", bus.bvalid, 0);
        check_eq("rst_perr", bus.proto_err, 0);
        check_eq("rst_rdata", bus.rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain read of unwritten memory, then the same with rready toggling
        do_read(32'hf0000040, 15, 0);
        do_read(32'hf0000040, 15, 1);

        // Full-word write then read around it
        push_beat(32'h11223344, 4'hf);
        push_beat(32'h55667788, 4'hf);
        do_write(32'hf0000004, 1, 1, 0);
        do_read(32'hf0000000, 3, 0);
        check_eq("ref_w1", exp_word(32'hf0000004), 32'h11223344);

        // Partial strobe into an unwritten word merges with the fill pattern
        push_beat(32'haaaabbbb, 4'h3);
        do_write(32'hf0000010, 0, 0, 0);
        do_read(32'hf0000010, 0, 0);
        check_eq("ref_strb", exp_word(32'hf0000010), 32'hf000bbbb);

        // Length extremes, including a 256-beat burst across the 32-bit wrap
        do_read(32'h00000100, 0, 0);
        do_read(32'hffffff00, 255, 2);

        // wlast asserted early on beat 1 of a 4-beat burst
        for (int i = 0; i < 4; i++) push_beat($urandom, 4'hf);
        do_write(32'hf0000080, 3, 1, 0);

        // Same-cycle write and read beat on the same word
        for (int i = 0; i < 4; i++) push_beat($urandom, 4'hf);
        fork
            do_write(32'hf0000100, 3, 3, 0);
            do_read(32'hf0000104, 3, 0);
        join

        // Randomized traffic, including aliased windows and concurrent bursts
        for (int it = 0; it < 40; it++) begin
            op   = $urandom_range(0, 2);
            base = ($urandom_range(0, 1) ? 32'hf0000000 : 32'h12340000) + 32'(4 * $urandom_range(0, 40));
            case (op)
                0: begin
                    len = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 12);
                    do_read(base, len, $urandom_range(0, 2));
                end
                1: begin
                    len = $urandom_range(0, 6);
                    for (int unsigned i = 0; i <= len; i++) push_beat($urandom, 4'($urandom_range(0, 15)));
                    do_write(base, len, ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : len, 1'($urandom_range(0, 1)));
                end
                default: begin
                    len = $urandom_range(0, 6);
                    for (int unsigned i = 0; i <= len; i++) push_beat($urandom, 4'($urandom_range(0, 15)));
                    fork
                        do_write(base, len, len, 1'($urandom_range(0, 1)));
                        do_read(base + 32'd4, $urandom_range(0, 8), $urandom_range(0, 2));
                    join
                end
            endcase
        end

        // Reset during beat 5 of a 16-beat read
        bus.araddr = 32'hf0000040; bus.arlen = 8'd15; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        hs = 0; cyc = 0;
        while (hs < 5 && cyc < 100) begin
            if (bus.rvalid) hs++;
            @(posedge clk); #1; cyc++;
        end
        check_eq("mid_beat5", bus.rdata, exp_word(32'hf0000054));
        rst = 1'b1;
        #1;
        model_clear();
        check_eq("mrst_rvalid", bus.rvalid, 0);
        check_eq("mrst_rlast", bus.rlast, 0);
        check_eq("mrst_arready", bus.arready, 1);
        check_eq("mrst_rdata", bus.rdata, 0);
        check_eq("mrst_perr", bus.proto_err, 0);
        bus.rready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_read(32'hf0000040, 15, 0);

        // Reset during a write burst: no B response may follow
        push_beat(32'hdeadbeef, 4'hf);
        push_beat(32'hcafef00d, 4'hf);
        bus.awaddr = 32'hf0000020; bus.awlen = 8'd7; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b1; bus.wstrb = 4'hf; bus.wlast = 1'b0;
        bus.wdata   = wd_q.pop_front(); void'(ws_q.pop_front());
        @(posedge clk); #1;
        bus.wdata   = wd_q.pop_front(); void'(ws_q.pop_front());
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wvalid = 1'b0;
        #1;
        model_clear();
        check_eq("wrst_wready", bus.wready, 0);
        check_eq("wrst_awready", bus.awready, 1);
        check_eq("wrst_bvalid", bus.bvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.bready = 1'b1;
        saw_b = 1'b0;
        repeat (20) begin
            if (bus.bvalid) saw_b = 1'b1;
            @(posedge clk); #1;
        end
        bus.bready = 1'b0;
        check_eq("no_b_after_rst", saw_b, 0);
        do_read(32'hf0000020, 7, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
